cu_vertex_cache_hit_responder: RTL and testbench
================================================

// Module: cu_vertex_cache_hit_responder
// PURPOSE
//  Responder end of the vertex-cache read path. The upstream reuse control tags a read command as a predicted hit.
//  This block serves that command from a local direct-mapped line store, or returns it on the miss path.
//  It sits beside the PULL PageRank global CU read port and emits response/data lines shaped like the memory read path.
//  The store is filled from data returned for real misses; write snoops and flush invalidate lines.
// PARAMETERS
//  NUM_LINES     16                    cache lines held, power of 2, 128B each as two 64B halves
//  INDEX_BITS    $clog2(NUM_LINES)     line index width
//  NUM_GRAPH_CU  NUM_GRAPH_CU_GLOBAL   carried for cu_id range checks only
// PORTS
//  clock               in   1                   single clock
//  rstn_in             in   1                   async active-low reset
//  enabled_in          in   1                   accept new commands when high
//  flush_in            in   1                   invalidate all lines (one-cycle pulse)
//  hit_command_in      in   CommandBufferLine   read command predicted to hit
//  hit_ready_out       out  1                   block can accept hit_command_in this cycle
//  fill_valid_in       in   1                   fill beat valid
//  fill_address_in     in   64                  128B-aligned line address of fill
//  fill_half_in        in   1                   0 = bytes 0-63, 1 = bytes 64-127
//  fill_data_in        in   512                 fill beat data
//  write_command_in    in   CommandBufferLine   write snoop; matching line is invalidated
//  miss_command_out    out  CommandBufferLine   command forwarded to memory on lookup miss
//  read_response_out   out  ResponseBufferLine  synthesized response
//  read_data_0_out     out  ReadWriteDataLine   first half of line
//  read_data_1_out     out  ReadWriteDataLine   second half of line
//  hit_count_out       out  32                  served hits, wraps
//  miss_count_out      out  32                  forwarded misses, wraps
// BEHAVIOUR
//  Reset: clock is the only clock; rstn_in is asynchronous active-low and is internally registered once.
//   On reset all outputs have valid=0, payload=0, and counters=0. All valid and half-valid bits clear; FSM=IDLE; hit_ready_out=0.
//  Index and tag: idx = address[7 +: INDEX_BITS]; tag = address[63:7+INDEX_BITS].
//   A line is usable only when valid and both half-valid bits are set.
//  FSM states: IDLE -> LOOKUP -> {DATA0 -> DATA1 -> RESP | MISS} -> IDLE.
//  IDLE: hit_ready_out = enabled_in registered. On hit_command_in.valid & hit_ready_out, latch the command (cycle N) and go to LOOKUP.
//  LOOKUP (N+1): a hit needs a usable line with tag equal to the command tag. A fill or snoop to the same idx in this cycle forces a miss.
//  Hit path timing:
//   read_data_0_out.valid at N+2, read_data_1_out.valid at N+3, read_response_out.valid at N+4.
//   Each valid lasts exactly one cycle.
//  Hit path payloads:
//   Data outputs: payload.cmd = latched command cmd; payload.data = stored half.
//   Response: payload.cmd = latched cmd; payload.response = DONE. hit_count_out += 1 at N+4.
//  MISS: miss_command_out = latched command, valid one cycle at N+2. miss_count_out += 1. No response or data is produced.
//  hit_ready_out is low from acceptance until the return to IDLE, so at most one command is in flight.
//  Fill: on a write beat to idx, the write sets tag, sets that half-valid, and clears the other half-valid if the tag changes.
//   The line becomes valid when both halves are present. Fills are accepted in every FSM state.
//  Snoop: write_command_in.valid with a matching idx and tag clears the line's valid bit next cycle.
//   A snoop and a fill to the same idx in the same cycle: the snoop wins and the line ends invalid.
//  flush_in: clears all valid bits next cycle. An in-flight hit that is already past LOOKUP completes with its latched data.
//  enabled_in low: no new accepts; an in-flight command completes.
//  Counters wrap 2^32-1 -> 0.
// STRUCTURE
//  CU_PKG holds cu_vertex_cache_line_t {tag, half_valid[2], valid} and the constants CACHE_LINE_OFFSET_BITS=7 and NUM_CACHE_LINES.
//  Sub-module cu_vertex_cache_line_store: tag/valid array plus a 2x512b data RAM, with a registered read port and fill/snoop write logic.
//  The top module holds the FSM, output registers and counters.
// TESTING
//  1. Fill 0x1000 as two beats, then hit cmd 0x1000 -> data_0 at N+2, data_1 at N+3, DONE at N+4. hit_count=1.
//  2. Cmd 0x2000 with the store empty -> miss_command_out at N+2 with identical payload. No response; miss_count=1.
//  3. Fill only half 0 of 0x1000, then cmd 0x1000 -> miss. Then fill half 1, and the same cmd -> hit.
//  4. With line 0x1000 valid, snoop write 0x1000 -> the next cmd 0x1000 misses. The same test with a snoop and fill together -> miss.
//  5. Fill 0x1000, then 0x1000+NUM_LINES*128 (same idx, new tag) -> cmd 0x1000 misses. Flush mid DATA1 -> response still DONE.
//  6. Assert reset during DATA0 -> all valids 0 immediately, counters 0. After release, cmd 0x1000 misses.

Source files
------------

// File: rtl/cu_vertex_cache_hit_responder_pkg.sv
// ----------------------------------------------------------------------------
// cu_vertex_cache_hit_responder_pkg
//   Shared types and constants for the vertex-cache hit responder.
//   - Command, response and read-data line shapes that mirror the memory read path.
//   - The per-line cache state record (tag, half-valid pair, valid).
//   - The responder FSM state encoding.
//   - A helper that tells whether a stored line may serve a hit.
// ----------------------------------------------------------------------------
package cu_vertex_cache_hit_responder_pkg;

   localparam int CACHE_LINE_OFFSET_BITS = 7;    // 128B lines
   localparam int NUM_CACHE_LINES        = 16;
   localparam int NUM_GRAPH_CU_GLOBAL    = 8;
   localparam int CACHE_DATA_BITS        = 512;  // one 64B half
   // Wide enough for the tag of any index width; upper bits are zero for larger stores.
   localparam int CACHE_TAG_BITS         = 64 - CACHE_LINE_OFFSET_BITS;

   typedef enum logic [1:0] {
      RSP_NONE  = 2'd0,
      RSP_DONE  = 2'd1,
      RSP_ERROR = 2'd2
   } cu_response_t;

   typedef struct packed {
      logic [63:0] address;
      logic [7:0]  cu_id;
      logic [7:0]  cmd_type;
      logic [15:0] cmd_tag;
   } cu_command_payload_t;

   typedef struct packed {
      logic                valid;
      cu_command_payload_t payload;
   } CommandBufferLine;

   typedef struct packed {
      cu_command_payload_t cmd;
      cu_response_t        response;
   } cu_response_payload_t;

   typedef struct packed {
      logic                 valid;
      cu_response_payload_t payload;
   } ResponseBufferLine;

   typedef struct packed {
      cu_command_payload_t        cmd;
      logic [CACHE_DATA_BITS-1:0] data;
   } cu_data_payload_t;

   typedef struct packed {
      logic             valid;
      cu_data_payload_t payload;
   } ReadWriteDataLine;

   typedef struct packed {
      logic [CACHE_TAG_BITS-1:0] tag;
      logic [1:0]                half_valid;
      logic                      valid;
   } cu_vertex_cache_line_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_DATA0  = 3'd2,
      ST_DATA1  = 3'd3,
      ST_RESP   = 3'd4,
      ST_MISS   = 3'd5
   } cu_vc_state_t;

   // A line can serve a hit only when it is valid and both halves are present.
   function automatic logic line_usable(input cu_vertex_cache_line_t line);
      return line.valid & line.half_valid[0] & line.half_valid[1];
   endfunction

endpackage

// File: rtl/cu_vertex_cache_line_store.sv
// ----------------------------------------------------------------------------
// cu_vertex_cache_line_store
//   Direct-mapped tag/valid array plus a 2 x 512b data RAM per line.
//   Ports:
//     clock, rst_n            clock and internal (already synchronised) reset
//     flush_in                clear every line's valid and half-valid bits
//     fill_*                  one 64B fill beat (idx, tag, half, data)
//     snoop_*                 write snoop (idx, tag); a matching line is dropped
//     lookup_idx/tag_in       combinational hit query; lookup_hit_out answers it
//     rd_en/idx/half_in       registered read port; rd_data_out one cycle later
// ----------------------------------------------------------------------------
module cu_vertex_cache_line_store
   import cu_vertex_cache_hit_responder_pkg::*;
#(
   parameter int NUM_LINES  = NUM_CACHE_LINES,
   parameter int INDEX_BITS = $clog2(NUM_LINES)
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic                       flush_in,
   input  logic                       fill_valid_in,
   input  logic [INDEX_BITS-1:0]      fill_idx_in,
   input  logic [CACHE_TAG_BITS-1:0]  fill_tag_in,
   input  logic                       fill_half_in,
   input  logic [CACHE_DATA_BITS-1:0] fill_data_in,
   input  logic                       snoop_valid_in,
   input  logic [INDEX_BITS-1:0]      snoop_idx_in,
   input  logic [CACHE_TAG_BITS-1:0]  snoop_tag_in,
   input  logic [INDEX_BITS-1:0]      lookup_idx_in,
   input  logic [CACHE_TAG_BITS-1:0]  lookup_tag_in,
   output logic                       lookup_hit_out,
   input  logic                       rd_en_in,
   input  logic [INDEX_BITS-1:0]      rd_idx_in,
   input  logic                       rd_half_in,
   output logic [CACHE_DATA_BITS-1:0] rd_data_out
);

   cu_vertex_cache_line_t      line_q [NUM_LINES];
   cu_vertex_cache_line_t      line_d [NUM_LINES];
   logic [CACHE_DATA_BITS-1:0] data_mem [NUM_LINES][2];
   logic [CACHE_DATA_BITS-1:0] rd_data_q;
   logic [CACHE_DATA_BITS-1:0] rd_data_d;
   cu_vertex_cache_line_t      lookup_line_s;
   logic                       fill_collide_s;
   logic                       snoop_collide_s;

   // Next tag/valid state: flush beats everything, a snoop beats a same-index fill.
   always_comb begin
      for (int i = 0; i < NUM_LINES; i++) begin
         line_d[i] = line_q[i];
         if (flush_in) begin
            line_d[i].valid      = 1'b0;
            line_d[i].half_valid = 2'b00;
         end else if (fill_valid_in && (fill_idx_in == INDEX_BITS'(i))) begin
            if (line_q[i].tag != fill_tag_in) begin
               // New owner: the other half still belongs to the old tag.
               line_d[i].tag        = fill_tag_in;
               line_d[i].half_valid = fill_half_in ? 2'b10 : 2'b01;
            end else begin
               line_d[i].half_valid[fill_half_in] = 1'b1;
            end
            if (snoop_valid_in && (snoop_idx_in == INDEX_BITS'(i))) begin
               line_d[i].valid      = 1'b0;
               line_d[i].half_valid = 2'b00;
            end else begin
               line_d[i].valid = line_d[i].half_valid[0] & line_d[i].half_valid[1];
            end
         end else if (snoop_valid_in && (snoop_idx_in == INDEX_BITS'(i)) &&
                      (line_q[i].tag == snoop_tag_in)) begin
            // Half-valids go too, so a later single-half refill cannot revive stale data.
            line_d[i].valid      = 1'b0;
            line_d[i].half_valid = 2'b00;
         end else begin
            line_d[i] = line_q[i];
         end
      end
   end

   // Tag/valid array register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            line_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_LINES; i++) begin
            line_q[i] <= line_d[i];
         end
      end
   end

   // Data RAM write port; contents are qualified by the valid bits, so no reset.
   always_ff @(posedge clock) begin
      if (fill_valid_in) begin
         data_mem[fill_idx_in][fill_half_in] <= fill_data_in;
      end
   end

   // Read-port next value: hold when idle, forward a same-cycle fill of the same half.
   always_comb begin
      if (!rd_en_in) begin
         rd_data_d = rd_data_q;
      end else if (fill_valid_in && (fill_idx_in == rd_idx_in) && (fill_half_in == rd_half_in)) begin
         rd_data_d = fill_data_in;
      end else begin
         rd_data_d = data_mem[rd_idx_in][rd_half_in];
      end
   end

   // Registered read port.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_out     = rd_data_q;
   assign lookup_line_s   = line_q[lookup_idx_in];
   assign fill_collide_s  = fill_valid_in & (fill_idx_in == lookup_idx_in);
   assign snoop_collide_s = snoop_valid_in & (snoop_idx_in == lookup_idx_in);

   // Hit query: any same-index fill or snoop this cycle makes the line untrustworthy.
   always_comb begin
      if (fill_collide_s || snoop_collide_s) begin
         lookup_hit_out = 1'b0;
      end else begin
         lookup_hit_out = line_usable(lookup_line_s) && (lookup_line_s.tag == lookup_tag_in);
      end
   end

endmodule

// File: rtl/cu_vertex_cache_hit_responder.sv
// ----------------------------------------------------------------------------
// cu_vertex_cache_hit_responder
//   Serves predicted-hit read commands from a local direct-mapped line store,
//   shaping the reply like the memory read path, or forwards the command to
//   memory when the lookup misses. One command in flight at a time.
//   Ports:
//     clock, rstn_in          clock; async active-low reset (registered once inside)
//     enabled_in              allow new commands
//     flush_in                invalidate every line
//     hit_command_in          predicted-hit read command; hit_ready_out accepts it
//     fill_*                  64B fill beats for 128B-aligned lines
//     write_command_in        write snoop; invalidates a matching line
//     miss_command_out        command forwarded to memory on a miss
//     read_response_out       DONE response for a served hit
//     read_data_0/1_out       the two 64B halves of a served hit
//     hit_count_out           served hits (wrapping)
//     miss_count_out          forwarded misses (wrapping)
// ----------------------------------------------------------------------------
module cu_vertex_cache_hit_responder
   import cu_vertex_cache_hit_responder_pkg::*;
#(
   parameter int NUM_LINES    = NUM_CACHE_LINES,
   parameter int INDEX_BITS   = $clog2(NUM_LINES),
   parameter int NUM_GRAPH_CU = NUM_GRAPH_CU_GLOBAL
) (
   input  logic                       clock,
   input  logic                       rstn_in,
   input  logic                       enabled_in,
   input  logic                       flush_in,
   input  CommandBufferLine           hit_command_in,
   output logic                       hit_ready_out,
   input  logic                       fill_valid_in,
   input  logic [63:0]                fill_address_in,
   input  logic                       fill_half_in,
   input  logic [CACHE_DATA_BITS-1:0] fill_data_in,
   input  CommandBufferLine           write_command_in,
   output CommandBufferLine           miss_command_out,
   output ResponseBufferLine          read_response_out,
   output ReadWriteDataLine           read_data_0_out,
   output ReadWriteDataLine           read_data_1_out,
   output logic [31:0]                hit_count_out,
   output logic [31:0]                miss_count_out
);

   localparam int TAG_SHIFT = CACHE_LINE_OFFSET_BITS + INDEX_BITS;

   logic                rst_n_q;
   cu_vc_state_t        state_q, state_d;
   cu_command_payload_t cmd_q, cmd_d;
   logic                hit_ready_q, hit_ready_d;
   CommandBufferLine    miss_q, miss_d;
   ResponseBufferLine   rsp_q, rsp_d;
   ReadWriteDataLine    data0_q, data0_d;
   ReadWriteDataLine    data1_q, data1_d;
   logic [31:0]         hit_cnt_q, hit_cnt_d;
   logic [31:0]         miss_cnt_q, miss_cnt_d;

   logic                       rd_en_s;
   logic [INDEX_BITS-1:0]      rd_idx_s;
   logic                       rd_half_s;
   logic [CACHE_DATA_BITS-1:0] rd_data_s;
   logic                       lookup_hit_s;
   logic                       cu_in_range_s;
   logic                       unused_addr_bits_s;

   // Reset asserts immediately and releases one clock after rstn_in rises.
   always_ff @(posedge clock or negedge rstn_in) begin
      if (!rstn_in) begin
         rst_n_q <= 1'b0;
      end else begin
         rst_n_q <= 1'b1;
      end
   end

   cu_vertex_cache_line_store #(
      .NUM_LINES  (NUM_LINES),
      .INDEX_BITS (INDEX_BITS)
   ) u_line_store (
      .clock          (clock),
      .rst_n          (rst_n_q),
      .flush_in       (flush_in),
      .fill_valid_in  (fill_valid_in),
      .fill_idx_in    (fill_address_in[CACHE_LINE_OFFSET_BITS +: INDEX_BITS]),
      .fill_tag_in    (CACHE_TAG_BITS'(fill_address_in >> TAG_SHIFT)),
      .fill_half_in   (fill_half_in),
      .fill_data_in   (fill_data_in),
      .snoop_valid_in (write_command_in.valid),
      .snoop_idx_in   (write_command_in.payload.address[CACHE_LINE_OFFSET_BITS +: INDEX_BITS]),
      .snoop_tag_in   (CACHE_TAG_BITS'(write_command_in.payload.address >> TAG_SHIFT)),
      .lookup_idx_in  (cmd_q.address[CACHE_LINE_OFFSET_BITS +: INDEX_BITS]),
      .lookup_tag_in  (CACHE_TAG_BITS'(cmd_q.address >> TAG_SHIFT)),
      .lookup_hit_out (lookup_hit_s),
      .rd_en_in       (rd_en_s),
      .rd_idx_in      (rd_idx_s),
      .rd_half_in     (rd_half_s),
      .rd_data_out    (rd_data_s)
   );

   // Commands from CUs outside the configured range are never served locally.
   assign cu_in_range_s = (32'(cmd_q.cu_id) < 32'(NUM_GRAPH_CU));

   // Only line address bits of fills and snoops matter; the rest is carried for shape.
   assign unused_addr_bits_s = ^{fill_address_in[CACHE_LINE_OFFSET_BITS-1:0],
                                 write_command_in.payload.address[CACHE_LINE_OFFSET_BITS-1:0],
                                 write_command_in.payload.cu_id,
                                 write_command_in.payload.cmd_type,
                                 write_command_in.payload.cmd_tag};

   // FSM next state, output registers and counters.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      miss_d     = '0;
      rsp_d      = '0;
      data0_d    = '0;
      data1_d    = '0;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      rd_en_s    = 1'b0;
      rd_idx_s   = cmd_q.address[CACHE_LINE_OFFSET_BITS +: INDEX_BITS];
      rd_half_s  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Half 0 is read speculatively so it is ready when LOOKUP decides.
            rd_en_s  = 1'b1;
            rd_idx_s = hit_command_in.payload.address[CACHE_LINE_OFFSET_BITS +: INDEX_BITS];
            if (hit_command_in.valid && hit_ready_q) begin
               cmd_d   = hit_command_in.payload;
               state_d = ST_LOOKUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            rd_en_s   = 1'b1;
            rd_half_s = 1'b1;
            if (lookup_hit_s && cu_in_range_s && !flush_in) begin
               data0_d.valid       = 1'b1;
               data0_d.payload.cmd = cmd_q;
               data0_d.payload.data = rd_data_s;
               state_d = ST_DATA0;
            end else begin
               miss_d.valid   = 1'b1;
               miss_d.payload = cmd_q;
               miss_cnt_d     = miss_cnt_q + 32'd1;
               state_d        = ST_MISS;
            end
         end
         ST_DATA0: begin
            data1_d.valid        = 1'b1;
            data1_d.payload.cmd  = cmd_q;
            data1_d.payload.data = rd_data_s;
            state_d = ST_DATA1;
         end
         ST_DATA1: begin
            rsp_d.valid            = 1'b1;
            rsp_d.payload.cmd      = cmd_q;
            rsp_d.payload.response = RSP_DONE;
            hit_cnt_d = hit_cnt_q + 32'd1;
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         ST_MISS: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Ready only while idle, so acceptance drops it until the command retires.
      hit_ready_d = (state_d == ST_IDLE) & enabled_in;
   end

   // State, latched command, outputs and counters.
   always_ff @(posedge clock or negedge rst_n_q) begin
      if (!rst_n_q) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         hit_ready_q <= 1'b0;
         miss_q      <= '0;
         rsp_q       <= '0;
         data0_q     <= '0;
         data1_q     <= '0;
         hit_cnt_q   <= 32'd0;
         miss_cnt_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         hit_ready_q <= hit_ready_d;
         miss_q      <= miss_d;
         rsp_q       <= rsp_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign hit_ready_out     = hit_ready_q;
   assign miss_command_out  = miss_q;
   assign read_response_out = rsp_q;
   assign read_data_0_out   = data0_q;
   assign read_data_1_out   = data1_q;
   assign hit_count_out     = hit_cnt_q;
   assign miss_count_out    = miss_cnt_q;

endmodule

// File: tb/tb_cu_vertex_cache_hit_responder.sv
module tb_cu_vertex_cache_hit_responder;
   import cu_vertex_cache_hit_responder_pkg::*;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              rstn_in;
   logic              enabled_in;
   logic              flush_in;
   CommandBufferLine  hit_command_in;
   logic              hit_ready_out;
   logic              fill_valid_in;
   logic [63:0]       fill_address_in;
   logic              fill_half_in;
   logic [511:0]      fill_data_in;
   CommandBufferLine  write_command_in;
   CommandBufferLine  miss_command_out;
   ResponseBufferLine read_response_out;
   ReadWriteDataLine  read_data_0_out;
   ReadWriteDataLine  read_data_1_out;
   logic [31:0]       hit_count_out;
   logic [31:0]       miss_count_out;

   int          n_checks   = 0;
   int          n_errors   = 0;
   int          exp_hits   = 0;
   int          exp_misses = 0;
   logic [15:0] next_tag   = 16'h0100;

   localparam logic [63:0] LINE_A = 64'h0000_0000_0000_1000;
   localparam logic [63:0] LINE_B = 64'h0000_0000_0000_2000;
   localparam logic [63:0] LINE_C = 64'h0000_0000_0000_1800; // LINE_A + 16*128: same idx, new tag
   localparam logic [511:0] D0A = {16{32'hA5A5_0001}};
   localparam logic [511:0] D1A = {16{32'h5A5A_0002}};
   localparam logic [511:0] D0B = {16{32'hB0B0_0003}};
   localparam logic [511:0] D1B = {16{32'h0B0B_0004}};
   localparam logic [511:0] D0C = {16{32'hC3C3_0005}};

   cu_vertex_cache_hit_responder dut (
      .clock             (clock),
      .rstn_in           (rstn_in),
      .enabled_in        (enabled_in),
      .flush_in          (flush_in),
      .hit_command_in    (hit_command_in),
      .hit_ready_out     (hit_ready_out),
      .fill_valid_in     (fill_valid_in),
      .fill_address_in   (fill_address_in),
      .fill_half_in      (fill_half_in),
      .fill_data_in      (fill_data_in),
      .write_command_in  (write_command_in),
      .miss_command_out  (miss_command_out),
      .read_response_out (read_response_out),
      .read_data_0_out   (read_data_0_out),
      .read_data_1_out   (read_data_1_out),
      .hit_count_out     (hit_count_out),
      .miss_count_out    (miss_count_out)
   );

   task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fill_half(input logic [63:0] addr, input logic half, input logic [511:0] data);
      fill_valid_in   = 1'b1;
      fill_address_in = addr;
      fill_half_in    = half;
      fill_data_in    = data;
      tick();
      fill_valid_in   = 1'b0;
      fill_address_in = 64'd0;
      fill_data_in    = '0;
   endtask

   task automatic fill_line(input logic [63:0] addr, input logic [511:0] d0, input logic [511:0] d1);
      fill_half(addr, 1'b0, d0);
      fill_half(addr, 1'b1, d1);
   endtask

   task automatic snoop(input logic [63:0] addr);
      write_command_in.valid           = 1'b1;
      write_command_in.payload.address = addr;
      tick();
      write_command_in = '0;
   endtask

   // Wait (bounded) for ready, present one command, return in its LOOKUP cycle.
   task automatic issue(input logic [63:0] addr, output cu_command_payload_t p);
      int waited = 0;
      while (hit_ready_out !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check_eq("ready_before_issue", hit_ready_out, 1'b1);
      p.address  = addr;
      p.cu_id    = 8'd0;
      p.cmd_type = 8'd2;
      p.cmd_tag  = next_tag;
      next_tag   = next_tag + 16'd1;
      hit_command_in.valid   = 1'b1;
      hit_command_in.payload = p;
      tick();
      hit_command_in = '0;
      check_eq("ready_low_in_flight", hit_ready_out, 1'b0);
   endtask

   task automatic expect_hit(input logic [63:0] addr, input logic [511:0] e0, input logic [511:0] e1,
                             input bit flush_mid);
      cu_command_payload_t p;
      issue(addr, p);
      tick(); // N+2
      check_eq("hit_d0_valid", read_data_0_out.valid, 1'b1);
      check_eq("hit_d0_cmd", read_data_0_out.payload.cmd, p);
      check_eq("hit_d0_data", read_data_0_out.payload.data, e0);
      check_eq("hit_d1_early", read_data_1_out.valid, 1'b0);
      check_eq("hit_no_miss", miss_command_out.valid, 1'b0);
      tick(); // N+3, DATA1
      if (flush_mid) flush_in = 1'b1;
      check_eq("hit_d0_one_cycle", read_data_0_out.valid, 1'b0);
      check_eq("hit_d1_valid", read_data_1_out.valid, 1'b1);
      check_eq("hit_d1_data", read_data_1_out.payload.data, e1);
      check_eq("hit_rsp_early", read_response_out.valid, 1'b0);
      tick(); // N+4
      flush_in = 1'b0;
      exp_hits++;
      check_eq("hit_rsp_valid", read_response_out.valid, 1'b1);
      check_eq("hit_rsp_code", read_response_out.payload.response, RSP_DONE);
      check_eq("hit_rsp_cmd", read_response_out.payload.cmd, p);
      check_eq("hit_d1_one_cycle", read_data_1_out.valid, 1'b0);
      check_eq("hit_count", hit_count_out, 32'(exp_hits));
      tick(); // N+5
      check_eq("hit_rsp_one_cycle", read_response_out.valid, 1'b0);
      check_eq("hit_ready_back", hit_ready_out, 1'b1);
   endtask

   // inject: 0 none, 1 fill half 0 (data D0C) in LOOKUP, 2 snoop in LOOKUP
   task automatic expect_miss(input logic [63:0] addr, input int inject);
      cu_command_payload_t p;
      issue(addr, p);
      if (inject == 1) begin
         fill_valid_in   = 1'b1;
         fill_address_in = addr;
         fill_half_in    = 1'b0;
         fill_data_in    = D0C;
      end else if (inject == 2) begin
         write_command_in.valid           = 1'b1;
         write_command_in.payload.address = addr;
      end
      tick(); // N+2
      fill_valid_in    = 1'b0;
      write_command_in = '0;
      exp_misses++;
      check_eq("miss_valid", miss_command_out.valid, 1'b1);
      check_eq("miss_payload", miss_command_out.payload, p);
      check_eq("miss_no_data", read_data_0_out.valid, 1'b0);
      check_eq("miss_count", miss_count_out, 32'(exp_misses));
      check_eq("miss_hit_count", hit_count_out, 32'(exp_hits));
      tick(); // N+3
      check_eq("miss_one_cycle", miss_command_out.valid, 1'b0);
      check_eq("miss_no_rsp", read_response_out.valid, 1'b0);
      check_eq("miss_no_data_late", read_data_0_out.valid | read_data_1_out.valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cu_command_payload_t p6;
      rstn_in          = 1'b0;
      enabled_in       = 1'b1;
      flush_in         = 1'b0;
      hit_command_in   = '0;
      fill_valid_in    = 1'b0;
      fill_address_in  = 64'd0;
      fill_half_in     = 1'b0;
      fill_data_in     = '0;
      write_command_in = '0;
      repeat (3) tick();
      check_eq("rst_ready", hit_ready_out, 1'b0);
      check_eq("rst_valids", {miss_command_out.valid, read_response_out.valid,
                              read_data_0_out.valid, read_data_1_out.valid}, 4'b0000);
      check_eq("rst_payloads", {miss_command_out, read_response_out}, '0);
      check_eq("rst_counts", {hit_count_out, miss_count_out}, 64'd0);
      rstn_in = 1'b1;

      // Empty store: plain miss.
      expect_miss(LINE_B, 0);

      // Two-beat fill then hit.
      fill_line(LINE_A, D0A, D1A);
      expect_hit(LINE_A, D0A, D1A, 1'b0);

      // Only half 0 present -> miss; second half arrives -> hit with new data.
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      fill_half(LINE_A, 1'b0, D0B);
      expect_miss(LINE_A, 0);
      fill_half(LINE_A, 1'b1, D1B);
      expect_hit(LINE_A, D0B, D1B, 1'b0);

      // Snoop invalidates; snoop+fill together leaves the line invalid.
      snoop(LINE_A);
      expect_miss(LINE_A, 0);
      fill_line(LINE_A, D0A, D1A);
      expect_hit(LINE_A, D0A, D1A, 1'b0);
      fill_valid_in    = 1'b1;
      fill_address_in  = LINE_A;
      fill_half_in     = 1'b1;
      fill_data_in     = D1A;
      write_command_in.valid           = 1'b1;
      write_command_in.payload.address = LINE_A;
      tick();
      fill_valid_in    = 1'b0;
      write_command_in = '0;
      expect_miss(LINE_A, 0);

      // Same-index fill or snoop during LOOKUP forces a miss.
      fill_line(LINE_A, D0A, D1A);
      expect_miss(LINE_A, 1);
      expect_hit(LINE_A, D0C, D1A, 1'b0);
      expect_miss(LINE_A, 2);
      expect_miss(LINE_A, 0);

      // Conflicting tag on the same index evicts; flush during DATA1 still completes.
      fill_line(LINE_A, D0A, D1A);
      fill_half(LINE_C, 1'b0, D0C);
      expect_miss(LINE_A, 0);
      expect_miss(LINE_C, 0);
      fill_line(LINE_A, D0A, D1A);
      expect_hit(LINE_A, D0A, D1A, 1'b1);
      expect_miss(LINE_A, 0);

      // Reset during DATA0 clears outputs at once; store is empty afterwards.
      fill_line(LINE_A, D0A, D1A);
      issue(LINE_A, p6);
      tick();
      check_eq("pre_rst_d0_valid", read_data_0_out.valid, 1'b1);
      rstn_in = 1'b0;
      #1;
      exp_hits   = 0;
      exp_misses = 0;
      check_eq("async_rst_d0", read_data_0_out.valid, 1'b0);
      check_eq("async_rst_counts", {hit_count_out, miss_count_out}, 64'd0);
      check_eq("async_rst_ready", hit_ready_out, 1'b0);
      repeat (2) tick();
      check_eq("rst_held_d1", read_data_1_out.valid | read_response_out.valid, 1'b0);
      rstn_in = 1'b1;
      expect_miss(LINE_A, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
